fifo_rd_ctrl: RTL

Read-side controller for the 8-deep x 32-bit register-file FIFO.
- Tracks occupancy from write-commit pulses issued by the write-side controller.
- Drives the register-file read address and registers the selected word onto dout.
- Raises rd_ack on a successful read and rd_err on a read attempted while empty.
- Sits between the register file and the FIFO consumer; the write-side controller is its only other peer.

---
 rtl/fifo_pkg.sv | 16 +
 rtl/fifo_rd_ctrl_dff_en_r.sv | 20 ++
 rtl/fifo_rd_ctrl.sv | 76 +++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the 8 x 32 register-file FIFO controllers.
// Both the read-side and write-side controllers import this package.
package fifo_pkg;

    localparam int FIFO_DW    = 32;
    localparam int FIFO_DEPTH = 8;
    localparam int FIFO_AW    = 3;

    typedef enum logic [1:0] {
        INIT     = 2'b00,
        IDLE     = 2'b01,
        READ     = 2'b10,
        RD_ERROR = 2'b11
    } state_t;

endpackage

// File: rtl/fifo_rd_ctrl_dff_en_r.sv
// DW-wide register with synchronous active-low reset and load enable.
module dff_en_r #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          en,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] q
);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller for the register-file FIFO: tracks occupancy, drives
// the read address, registers the head word onto dout, flags ack/error.
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int DW    = FIFO_DW,
    parameter int DEPTH = FIFO_DEPTH,
    parameter int AW    = FIFO_AW
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          rd_en,
    input  logic          wr_commit,
    input  logic [DW-1:0] rf_rdata,
    output logic [AW-1:0] rd_addr,
    output logic [DW-1:0] dout,
    output logic          rd_ack,
    output logic          rd_err,
    output logic          empty,
    output logic [AW:0]   data_count,
    output state_t        fsm_state
);

    // Handshake: rd_en is a request sampled every rising edge with no
    // backpressure; it is granted when data_count > 0, and the grant shows
    // up one cycle later as rd_ack with dout valid, or as rd_err if refused.
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    state_t state;
    logic   rd_ok;

    assign rd_ok = rd_en && (data_count != '0);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= INIT;
            rd_addr    <= '0;
            data_count <= '0;
        end else begin
            if (!rd_en) begin
                state <= IDLE;
            end else if (rd_ok) begin
                state <= READ;
            end else begin
                state <= RD_ERROR;
            end

            // DEPTH is a power of two, so the natural AW-bit overflow wraps.
            if (rd_ok) begin
                rd_addr <= rd_addr + 1'b1;
            end

            case ({wr_commit, rd_ok})
                2'b10: if (data_count != FULL_COUNT) data_count <= data_count + 1'b1;
                2'b01: data_count <= data_count - 1'b1;
                default: data_count <= data_count;
            endcase
        end
    end

    assign rd_ack    = (state == READ);
    assign rd_err    = (state == RD_ERROR);
    assign empty     = (data_count == '0);
    assign fsm_state = state;

    dff_en_r #(
        .DW(DW)
    ) u_dout_reg (
        .clk    (clk),
        .reset_n(reset_n),
        .en     (rd_ok),
        .d      (rf_rdata),
        .q      (dout)
    );

endmodule
